// File: rtl/id_ex_stage_pkg.sv
// Shared CPU definitions: opcodes, ALUOp encodings and the ID/EX control bundle.
package id_ex_stage_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned FUNCT_W    = 10;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use detector: EX holds a load whose destination is a source of the ID instruction.
module id_ex_stage_hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic                  mem_read,
    input  logic                  valid,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  hazard_stall_c
);

    // Both sources are compared even if the instruction ignores one (conservative).
    assign hazard_stall_c = mem_read & valid & (rd_addr != '0)
                          & ((rd_addr == rs1_addr) | (rd_addr == rs2_addr));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion, load-use detection and a saturating bubble counter.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic [1:0]            ALUOp_i,
    input  logic                  ALUSrc_i,
    input  logic                  MemRead_i,
    input  logic                  MemWrite_i,
    input  logic                  RegWrite_i,
    input  logic                  MemtoReg_i,
    input  logic [DATA_W-1:0]     RS1data_i,
    input  logic [DATA_W-1:0]     RS2data_i,
    input  logic [DATA_W-1:0]     Imm_i,
    input  logic [FUNCT_W-1:0]    funct_i,
    input  logic [REG_ADDR_W-1:0] RS1addr_i,
    input  logic [REG_ADDR_W-1:0] RS2addr_i,
    input  logic [REG_ADDR_W-1:0] RDaddr_i,
    output logic [1:0]            ALUOp_o,
    output logic                  ALUSrc_o,
    output logic                  MemRead_o,
    output logic                  MemWrite_o,
    output logic                  RegWrite_o,
    output logic                  MemtoReg_o,
    output logic [DATA_W-1:0]     RS1data_o,
    output logic [DATA_W-1:0]     RS2data_o,
    output logic [DATA_W-1:0]     Imm_o,
    output logic [FUNCT_W-1:0]    funct_o,
    output logic [REG_ADDR_W-1:0] RS1addr_o,
    output logic [REG_ADDR_W-1:0] RS2addr_o,
    output logic [REG_ADDR_W-1:0] RDaddr_o,
    output logic                  valid_o,
    output logic                  hazard_stall_o,
    output logic [CNT_W-1:0]      bubble_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ctrl_t                 ctrl_in;
    ctrl_t                 ctrl_q;
    logic                  valid_q;
    logic [DATA_W-1:0]     rs1_data_q;
    logic [DATA_W-1:0]     rs2_data_q;
    logic [DATA_W-1:0]     imm_q;
    logic [FUNCT_W-1:0]    funct_q;
    logic [REG_ADDR_W-1:0] rs1_addr_q;
    logic [REG_ADDR_W-1:0] rs2_addr_q;
    logic [REG_ADDR_W-1:0] rd_addr_q;
    logic [CNT_W-1:0]      bubble_cnt_q;
    logic                  hazard_c;
    logic                  bubble_c;

    assign ctrl_in = '{alu_op:     ALUOp_i,
                       alu_src:    ALUSrc_i,
                       mem_read:   MemRead_i,
                       mem_write:  MemWrite_i,
                       reg_write:  RegWrite_i,
                       mem_to_reg: MemtoReg_i};

    id_ex_stage_hazard_detect hazard_detect (
        .mem_read       (ctrl_q.mem_read),
        .valid          (valid_q),
        .rd_addr        (rd_addr_q),
        .rs1_addr       (RS1addr_i),
        .rs2_addr       (RS2addr_i),
        .hazard_stall_c (hazard_c)
    );

    assign bubble_c = flush_i | hazard_c;

    // Memory stall freezes everything; a bubble still loads the don't-care data fields.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ctrl_q       <= '0;
            valid_q      <= 1'b0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            funct_q      <= '0;
            rs1_addr_q   <= '0;
            rs2_addr_q   <= '0;
            rd_addr_q    <= '0;
            bubble_cnt_q <= '0;
        end else if (!stall_i) begin
            rs1_data_q <= RS1data_i;
            rs2_data_q <= RS2data_i;
            imm_q      <= Imm_i;
            funct_q    <= funct_i;
            rs1_addr_q <= RS1addr_i;
            rs2_addr_q <= RS2addr_i;
            rd_addr_q  <= RDaddr_i;
            if (bubble_c) begin
                ctrl_q  <= '0;
                valid_q <= 1'b0;
                if (bubble_cnt_q != CNT_MAX) begin
                    bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
                end
            end else begin
                ctrl_q  <= ctrl_in;
                valid_q <= 1'b1;
            end
        end
    end

    assign ALUOp_o        = ctrl_q.alu_op;
    assign ALUSrc_o       = ctrl_q.alu_src;
    assign MemRead_o      = ctrl_q.mem_read;
    assign MemWrite_o     = ctrl_q.mem_write;
    assign RegWrite_o     = ctrl_q.reg_write;
    assign MemtoReg_o     = ctrl_q.mem_to_reg;
    assign RS1data_o      = rs1_data_q;
    assign RS2data_o      = rs2_data_q;
    assign Imm_o          = imm_q;
    assign funct_o        = funct_q;
    assign RS1addr_o      = rs1_addr_q;
    assign RS2addr_o      = rs2_addr_q;
    assign RDaddr_o       = rd_addr_q;
    assign valid_o        = valid_q;
    assign hazard_stall_o = hazard_c;
    assign bubble_cnt_o   = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a behavioural pipeline-register model.
module tb_id_ex_stage;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic stall_i, flush_i;
    logic [1:0] ALUOp_i;
    logic ALUSrc_i, MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i;
    logic [DATA_W-1:0] RS1data_i, RS2data_i, Imm_i;
    logic [9:0] funct_i;
    logic [4:0] RS1addr_i, RS2addr_i, RDaddr_i;
    logic [1:0] ALUOp_o;
    logic ALUSrc_o, MemRead_o, MemWrite_o, RegWrite_o, MemtoReg_o;
    logic [DATA_W-1:0] RS1data_o, RS2data_o, Imm_o;
    logic [9:0] funct_o;
    logic [4:0] RS1addr_o, RS2addr_o, RDaddr_o;
    logic valid_o, hazard_stall_o;
    logic [CNT_W-1:0] bubble_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: what the EX side should hold.
    logic              m_valid, m_alusrc, m_memread, m_memwrite, m_regwrite, m_memtoreg;
    logic [1:0]        m_aluop;
    logic [DATA_W-1:0] m_rs1d, m_rs2d, m_imm;
    logic [9:0]        m_funct;
    logic [4:0]        m_rs1a, m_rs2a, m_rda;
    int                m_cnt;

    always #5 clk_i = ~clk_i;

    id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .ALUOp_i(ALUOp_i), .ALUSrc_i(ALUSrc_i), .MemRead_i(MemRead_i),
        .MemWrite_i(MemWrite_i), .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
        .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .Imm_i(Imm_i), .funct_i(funct_i),
        .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
        .ALUOp_o(ALUOp_o), .ALUSrc_o(ALUSrc_o), .MemRead_o(MemRead_o),
        .MemWrite_o(MemWrite_o), .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
        .RS1data_o(RS1data_o), .RS2data_o(RS2data_o), .Imm_o(Imm_o), .funct_o(funct_o),
        .RS1addr_o(RS1addr_o), .RS2addr_o(RS2addr_o), .RDaddr_o(RDaddr_o),
        .valid_o(valid_o), .hazard_stall_o(hazard_stall_o), .bubble_cnt_o(bubble_cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_hazard();
        return m_valid && m_memread && (m_rda != 5'd0) &&
               ((m_rda == RS1addr_i) || (m_rda == RS2addr_i));
    endfunction

    task automatic model_reset();
        {m_valid, m_alusrc, m_memread, m_memwrite, m_regwrite, m_memtoreg} = '0;
        m_aluop = '0; m_rs1d = '0; m_rs2d = '0; m_imm = '0; m_funct = '0;
        m_rs1a = '0; m_rs2a = '0; m_rda = '0; m_cnt = 0;
    endtask

    task automatic check_outputs();
        check("aluop",    64'(ALUOp_o),    64'(m_aluop));
        check("alusrc",   64'(ALUSrc_o),   64'(m_alusrc));
        check("memread",  64'(MemRead_o),  64'(m_memread));
        check("memwrite", 64'(MemWrite_o), 64'(m_memwrite));
        check("regwrite", 64'(RegWrite_o), 64'(m_regwrite));
        check("memtoreg", 64'(MemtoReg_o), 64'(m_memtoreg));
        check("rs1data",  64'(RS1data_o),  64'(m_rs1d));
        check("rs2data",  64'(RS2data_o),  64'(m_rs2d));
        check("imm",      64'(Imm_o),      64'(m_imm));
        check("funct",    64'(funct_o),    64'(m_funct));
        check("rs1addr",  64'(RS1addr_o),  64'(m_rs1a));
        check("rs2addr",  64'(RS2addr_o),  64'(m_rs2a));
        check("rdaddr",   64'(RDaddr_o),   64'(m_rda));
        check("valid",    64'(valid_o),    64'(m_valid));
        check("bubble_cnt", 64'(bubble_cnt_o), 64'(m_cnt));
    endtask

    // One clock: check the combinational hazard, clock, advance the model, check the register.
    task automatic step();
        logic haz;
        #1;
        haz = model_hazard();
        check("hazard_stall", 64'(hazard_stall_o), 64'(haz));
        @(posedge clk_i);
        if (!stall_i) begin
            m_rs1d = RS1data_i; m_rs2d = RS2data_i; m_imm = Imm_i; m_funct = funct_i;
            m_rs1a = RS1addr_i; m_rs2a = RS2addr_i; m_rda = RDaddr_i;
            if (flush_i || haz) begin
                {m_valid, m_alusrc, m_memread, m_memwrite, m_regwrite, m_memtoreg} = '0;
                m_aluop = '0;
                if (m_cnt < CNT_MAX) m_cnt++;
            end else begin
                m_valid = 1'b1; m_aluop = ALUOp_i; m_alusrc = ALUSrc_i;
                m_memread = MemRead_i; m_memwrite = MemWrite_i;
                m_regwrite = RegWrite_i; m_memtoreg = MemtoReg_i;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic rand_instr();
        ALUOp_i    = 2'($urandom);
        ALUSrc_i   = 1'($urandom);
        MemRead_i  = 1'($urandom);
        MemWrite_i = 1'($urandom);
        RegWrite_i = 1'($urandom);
        MemtoReg_i = 1'($urandom);
        RS1data_i  = $urandom;
        RS2data_i  = $urandom;
        Imm_i      = $urandom;
        funct_i    = 10'($urandom);
        RS1addr_i  = 5'($urandom_range(0, 3));
        RS2addr_i  = 5'($urandom_range(0, 3));
        RDaddr_i   = 5'($urandom_range(0, 3));
    endtask

    task automatic load_instr(input logic mem_read, input logic [4:0] rd);
        rand_instr();
        stall_i = 1'b0; flush_i = 1'b0;
        MemRead_i = mem_read; RDaddr_i = rd;
        RS1addr_i = 5'd20; RS2addr_i = 5'd21;
        step();
    endtask

    // Resets between clock edges and releases just after the next rising edge.
    task automatic do_reset();
        #2;
        rst_i = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check("hazard_in_reset", 64'(hazard_stall_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
    endtask

    initial begin
        int cnt0;
        stall_i = 1'b0; flush_i = 1'b0;
        rand_instr();
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check_outputs();
        rst_i = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rand_instr();
            stall_i = ($urandom_range(0, 99) < 15);
            flush_i = ($urandom_range(0, 99) < 10);
            step();
        end

        // Asynchronous reset with a real instruction and nonzero count in EX
        do_reset();
        flush_i = 1'b1; stall_i = 1'b0;
        repeat (5) step();
        load_instr(1'b1, 5'd7);
        check("pre_reset_valid", 64'(valid_o), 64'd1);
        check("pre_reset_cnt", 64'(bubble_cnt_o), 64'd5);
        do_reset();

        // Load-use: lw x5 in EX, ID reads x5 through rs1
        load_instr(1'b1, 5'd5);
        cnt0 = m_cnt;
        rand_instr();
        RS1addr_i = 5'd5; RS2addr_i = 5'd9; MemRead_i = 1'b0; RDaddr_i = 5'd6;
        #1;
        check("loaduse_hazard", 64'(hazard_stall_o), 64'd1);
        step();
        check("loaduse_valid", 64'(valid_o), 64'd0);
        check("loaduse_ctrl", 64'({ALUOp_o, ALUSrc_o, MemRead_o, MemWrite_o, RegWrite_o, MemtoReg_o}), 64'd0);
        check("loaduse_cnt", 64'(bubble_cnt_o), 64'(cnt0 + 1));
        check("loaduse_release", 64'(hazard_stall_o), 64'd0);

        // x0 destination never stalls
        load_instr(1'b1, 5'd0);
        rand_instr();
        RS1addr_i = 5'd3; RS2addr_i = 5'd0;
        #1;
        check("x0_hazard", 64'(hazard_stall_o), 64'd0);
        step();
        check("x0_loads", 64'(valid_o), 64'd1);

        // Memory stall with flush held for three cycles
        cnt0 = m_cnt;
        for (int i = 0; i < 3; i++) begin
            rand_instr();
            stall_i = 1'b1; flush_i = 1'b1;
            step();
            check("stall_cnt_hold", 64'(bubble_cnt_o), 64'(cnt0));
            check("stall_valid_hold", 64'(valid_o), 64'd1);
        end
        stall_i = 1'b0;
        step();
        check("post_stall_flush_cnt", 64'(bubble_cnt_o), 64'(cnt0 + 1));

        // Flush together with a load-use hazard: a single bubble
        load_instr(1'b1, 5'd2);
        cnt0 = m_cnt;
        rand_instr();
        RS2addr_i = 5'd2; flush_i = 1'b1; stall_i = 1'b0;
        #1;
        check("simul_hazard", 64'(hazard_stall_o), 64'd1);
        step();
        check("simul_cnt", 64'(bubble_cnt_o), 64'(cnt0 + 1));
        check("simul_valid", 64'(valid_o), 64'd0);

        // Saturation of the 4-bit counter
        do_reset();
        flush_i = 1'b1; stall_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rand_instr();
            step();
        end
        check("saturate_cnt", 64'(bubble_cnt_o), 64'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
